axil_mstr_replayer: RTL and testbench

- Replay-side counterpart of the AXI-Lite master recorder.
- Consumes the recorded master stream (per-packet header plus AW/W/AR payloads) and re-issues those transactions on an AXI-Lite master port toward the CL.
- Per-channel order is preserved; AW, W and AR drain independently.
- B and R responses are sunk and counted; non-OKAY responses are flagged.

---
 rtl/axil_mstr_replayer_if.sv | 30 +++
 rtl/axil_mstr_replayer.sv | 200 ++++++++++++++++++++
 tb/tb_axil_mstr_replayer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_mstr_replayer_if.sv
// AXI-Lite bus bundle between the replayer (master) and the CL (slave).
interface axil_mstr_replayer_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, bready, rready,
    input  awready, wready, arready, bresp, bvalid, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, bready, rready,
    output awready, wready, arready, bresp, bvalid, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_mstr_replayer.sv
// AXI-Lite master replayer: buffers recorded AW/W/AR payloads per channel and
// re-issues them in order, sinking and counting B/R responses.

// Per-channel buffer. The head entry is read straight out of the register
// array at the registered read pointer, so it is stable while not popped.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axil_mstr_replayer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Pointer advance on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // Pointer registers; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  assign head  = mem[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;
endmodule

module axil_mstr_replayer #(
  parameter int FIFO_DEPTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        async_rst,
  input  logic        rep_valid,
  output logic        rep_ready,
  input  logic        rep_hdr_aw,
  input  logic        rep_hdr_w,
  input  logic        rep_hdr_ar,
  input  logic [31:0] rep_awaddr,
  input  logic [31:0] rep_wdata,
  input  logic [3:0]  rep_wstrb,
  input  logic [31:0] rep_araddr,
  axil_mstr_replayer_if.master m_axil,
  output logic [7:0]  wr_outstanding,
  output logic [7:0]  rd_outstanding,
  output logic        resp_err,
  output logic        idle
);
  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [7:0]    MAX_OUT = 8'(MAX_OUTSTANDING);

  logic [CW-1:0] aw_cnt, w_cnt, ar_cnt;
  logic [CW-1:0] aw_cnt_nxt, w_cnt_nxt, ar_cnt_nxt;
  logic [31:0]   aw_head, ar_head;
  logic [35:0]   w_head;

  logic run_q, run_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic arvalid_q, arvalid_d;
  logic [7:0] wr_out_q, wr_out_d;
  logic [7:0] rd_out_q, rd_out_d;
  logic resp_err_q, resp_err_d;

  logic accept, aw_push, w_push, ar_push;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  // Acceptance depends only on registered fill levels and the header, so a
  // packet is taken whole or not at all, and a pop in the same cycle as a
  // full condition does not free a slot until the following cycle.
  always_comb begin
    rep_ready = run_q
             && (!rep_hdr_aw || aw_cnt != FULL)
             && (!rep_hdr_w  || w_cnt  != FULL)
             && (!rep_hdr_ar || ar_cnt != FULL);
    accept  = rep_valid && rep_ready;
    aw_push = accept && rep_hdr_aw;
    w_push  = accept && rep_hdr_w;
    ar_push = accept && rep_hdr_ar;
    aw_hs   = awvalid_q && m_axil.awready;
    w_hs    = wvalid_q  && m_axil.wready;
    ar_hs   = arvalid_q && m_axil.arready;
    b_hs    = m_axil.bvalid && run_q;
    r_hs    = m_axil.rvalid && run_q;
  end

  axil_mstr_replayer_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
    .clk(clk), .rst(async_rst), .push(aw_push), .pop(aw_hs),
    .din(rep_awaddr), .head(aw_head), .count(aw_cnt)
  );

  axil_mstr_replayer_fifo #(.WIDTH(36), .DEPTH(FIFO_DEPTH)) u_w_fifo (
    .clk(clk), .rst(async_rst), .push(w_push), .pop(w_hs),
    .din({rep_wstrb, rep_wdata}), .head(w_head), .count(w_cnt)
  );

  axil_mstr_replayer_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
    .clk(clk), .rst(async_rst), .push(ar_push), .pop(ar_hs),
    .din(rep_araddr), .head(ar_head), .count(ar_cnt)
  );

  // Next-state: outstanding accounting, sticky error, and channel valids.
  // A valid is raised when the buffer will hold an entry next cycle and, for
  // AW/AR, the next outstanding count leaves room; a raised valid is held
  // until its handshake regardless of the limit.
  always_comb begin
    run_d      = 1'b1;
    wr_out_d   = wr_out_q;
    rd_out_d   = rd_out_q;
    resp_err_d = resp_err_q;

    if (aw_hs && !b_hs) begin
      wr_out_d = wr_out_q + 8'd1;
    end else if (b_hs && !aw_hs) begin
      if (wr_out_q == 8'd0) resp_err_d = 1'b1;
      else                  wr_out_d   = wr_out_q - 8'd1;
    end

    if (ar_hs && !r_hs) begin
      rd_out_d = rd_out_q + 8'd1;
    end else if (r_hs && !ar_hs) begin
      if (rd_out_q == 8'd0) resp_err_d = 1'b1;
      else                  rd_out_d   = rd_out_q - 8'd1;
    end

    if (b_hs && m_axil.bresp != 2'b00) resp_err_d = 1'b1;
    if (r_hs && m_axil.rresp != 2'b00) resp_err_d = 1'b1;

    aw_cnt_nxt = aw_cnt + CW'(aw_push) - CW'(aw_hs);
    w_cnt_nxt  = w_cnt  + CW'(w_push)  - CW'(w_hs);
    ar_cnt_nxt = ar_cnt + CW'(ar_push) - CW'(ar_hs);

    awvalid_d = (awvalid_q && !m_axil.awready)
             || (aw_cnt_nxt != '0 && wr_out_d < MAX_OUT);
    wvalid_d  = (wvalid_q && !m_axil.wready) || (w_cnt_nxt != '0);
    arvalid_d = (arvalid_q && !m_axil.arready)
             || (ar_cnt_nxt != '0 && rd_out_d < MAX_OUT);
  end

  // State registers; reset drops everything at once.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      run_q      <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      wr_out_q   <= 8'd0;
      rd_out_q   <= 8'd0;
      resp_err_q <= 1'b0;
    end else begin
      run_q      <= run_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      wr_out_q   <= wr_out_d;
      rd_out_q   <= rd_out_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign m_axil.awvalid = awvalid_q;
  assign m_axil.awaddr  = aw_head;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.wdata   = w_head[31:0];
  assign m_axil.wstrb   = w_head[35:32];
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.araddr  = ar_head;
  assign m_axil.bready  = run_q;
  assign m_axil.rready  = run_q;

  assign wr_outstanding = wr_out_q;
  assign rd_outstanding = rd_out_q;
  assign resp_err       = resp_err_q;
  assign idle = (aw_cnt == '0) && (w_cnt == '0) && (ar_cnt == '0)
             && (wr_out_q == 8'd0) && (rd_out_q == 8'd0);
endmodule

// File: tb/tb_axil_mstr_replayer.sv
// Directed bench for axil_mstr_replayer (FIFO_DEPTH=32, MAX_OUTSTANDING=8).
module tb_axil_mstr_replayer;
  logic        clk = 1'b0;
  logic        async_rst;
  logic        rep_valid, rep_ready;
  logic        rep_hdr_aw, rep_hdr_w, rep_hdr_ar;
  logic [31:0] rep_awaddr, rep_wdata, rep_araddr;
  logic [3:0]  rep_wstrb;
  logic [7:0]  wr_outstanding, rd_outstanding;
  logic        resp_err, idle;

  int n_cmp = 0;
  int n_err = 0;
  int pi, k, nr, pw, nw;

  axil_mstr_replayer_if bus();

  axil_mstr_replayer #(.FIFO_DEPTH(32), .MAX_OUTSTANDING(8)) dut (
    .clk(clk), .async_rst(async_rst),
    .rep_valid(rep_valid), .rep_ready(rep_ready),
    .rep_hdr_aw(rep_hdr_aw), .rep_hdr_w(rep_hdr_w), .rep_hdr_ar(rep_hdr_ar),
    .rep_awaddr(rep_awaddr), .rep_wdata(rep_wdata), .rep_wstrb(rep_wstrb),
    .rep_araddr(rep_araddr),
    .m_axil(bus.master),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .resp_err(resp_err), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input bit a, input bit w, input bit r, input logic [31:0] aa,
                      input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ra);
    rep_valid = 1'b1; rep_hdr_aw = a; rep_hdr_w = w; rep_hdr_ar = r;
    rep_awaddr = aa; rep_wdata = wd; rep_wstrb = ws; rep_araddr = ra;
    #1;
    for (int c = 0; c < 50 && !rep_ready; c++) begin
      @(negedge clk); #1;
    end
    chk("send_ready", rep_ready, 1);
    @(negedge clk);
    rep_valid = 1'b0; rep_hdr_aw = 1'b0; rep_hdr_w = 1'b0; rep_hdr_ar = 1'b0;
  endtask

  // AR stream runner: feeds AR packets 0..39, counts/validates AR issue order,
  // optionally returns R beats for every outstanding read.
  task automatic ar_run(input int cycles, input bit auto_r);
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (bus.arvalid && bus.arready) begin
        chk("ar_order", bus.araddr, 32'h1000 + 32'(4 * k));
        k++;
      end
      if (bus.rvalid && bus.rready) nr++;
      if (rep_valid && rep_ready) pi++;
      @(negedge clk);
      rep_valid  = (pi < 40);
      rep_hdr_ar = (pi < 40);
      rep_araddr = 32'h1000 + 32'(4 * pi);
      bus.rvalid = auto_r && (nr < k);
    end
  endtask

  initial begin
    async_rst = 1'b1;
    rep_valid = 0; rep_hdr_aw = 0; rep_hdr_w = 0; rep_hdr_ar = 0;
    rep_awaddr = 0; rep_wdata = 0; rep_wstrb = 0; rep_araddr = 0;
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;

    // Reset state
    #12;
    chk("rst_rep_ready", rep_ready, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_idle", idle, 1);
    chk("rst_resp_err", resp_err, 0);
    @(negedge clk); async_rst = 1'b0;
    @(negedge clk); #1;
    chk("bready_after_rst", bus.bready, 1);
    chk("rready_after_rst", bus.rready, 1);

    // Write pair
    bus.awready = 1; bus.wready = 1;
    send(1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
    #1;
    chk("wp_awvalid", bus.awvalid, 1);
    chk("wp_awaddr", bus.awaddr, 32'h10);
    chk("wp_wvalid", bus.wvalid, 1);
    chk("wp_wdata", bus.wdata, 32'hDEAD_BEEF);
    chk("wp_wstrb", bus.wstrb, 4'hF);
    chk("wp_out0", wr_outstanding, 0);
    @(negedge clk); #1;
    chk("wp_awvalid_drop", bus.awvalid, 0);
    chk("wp_wvalid_drop", bus.wvalid, 0);
    chk("wp_out1", wr_outstanding, 1);
    chk("wp_not_idle", idle, 0);
    bus.bvalid = 1; bus.bresp = 2'b00;
    @(negedge clk); bus.bvalid = 0; #1;
    chk("wp_out_back0", wr_outstanding, 0);
    chk("wp_idle", idle, 1);
    chk("wp_resp_err", resp_err, 0);

    // Three AW-only writes, then simultaneous AW+B at count 3
    @(negedge clk);
    for (int i = 0; i < 3; i++) send(1, 0, 0, 32'h20 + 32'(4 * i), 0, 0, 0);
    @(negedge clk); #1;
    chk("sim_out3", wr_outstanding, 3);
    bus.awready = 0;
    @(negedge clk);
    send(1, 0, 0, 32'h40, 0, 0, 0);
    #1;
    chk("sim_aw_held", bus.awvalid, 1);
    chk("sim_aw_addr", bus.awaddr, 32'h40);
    chk("sim_out3b", wr_outstanding, 3);
    bus.awready = 1; bus.bvalid = 1; bus.bresp = 2'b00;
    @(negedge clk); #1;
    chk("sim_aw_done", bus.awvalid, 0);
    chk("sim_out_same", wr_outstanding, 3);
    chk("sim_no_err", resp_err, 0);
    // Error response, then OKAY responses keep the flag set
    bus.bresp = 2'b10;
    @(negedge clk); bus.bresp = 2'b00; #1;
    chk("err_set", resp_err, 1);
    chk("err_out2", wr_outstanding, 2);
    @(negedge clk);
    @(negedge clk); bus.bvalid = 0; #1;
    chk("err_out0", wr_outstanding, 0);
    chk("err_sticky", resp_err, 1);

    // Mixed headers with a bubble, all channels stalled while loading
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    @(negedge clk);
    send(1, 0, 0, 32'h100, 0, 0, 0);
    send(0, 0, 0, 32'hBAD0, 32'hBAD0, 4'h0, 32'hBAD0);
    send(0, 1, 1, 32'hBAD1, 32'h1111_1111, 4'h3, 32'h200);
    send(1, 1, 1, 32'h104, 32'h2222_2222, 4'hC, 32'h204);
    #1;
    chk("mx_aw0", bus.awaddr, 32'h100);
    chk("mx_w0", bus.wdata, 32'h1111_1111);
    chk("mx_s0", bus.wstrb, 4'h3);
    chk("mx_ar0", bus.araddr, 32'h200);
    chk("mx_valids0", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b111);
    bus.awready = 1; bus.wready = 1; bus.arready = 1;
    @(negedge clk); #1;
    chk("mx_aw1", bus.awaddr, 32'h104);
    chk("mx_w1", bus.wdata, 32'h2222_2222);
    chk("mx_s1", bus.wstrb, 4'hC);
    chk("mx_ar1", bus.araddr, 32'h204);
    chk("mx_valids1", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b111);
    @(negedge clk); #1;
    chk("mx_valids_end", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b000);
    chk("mx_wr_out", wr_outstanding, 2);
    chk("mx_rd_out", rd_outstanding, 2);
    bus.bvalid = 1; bus.rvalid = 1;
    @(negedge clk);
    @(negedge clk); bus.bvalid = 0; bus.rvalid = 0; #1;
    chk("mx_drained", {wr_outstanding, rd_outstanding}, 16'h0000);
    chk("mx_idle", idle, 1);

    // Synchronous-release reset clears sticky error
    async_rst = 1;
    @(negedge clk); async_rst = 0; #1;
    chk("rst2_resp_err", resp_err, 0);

    // AR backpressure and outstanding limit
    bus.arready = 0; bus.rvalid = 0;
    pi = 0; k = 0; nr = 0;
    @(negedge clk);
    rep_valid = 1; rep_hdr_ar = 1; rep_araddr = 32'h1000;
    ar_run(40, 0);
    #1;
    chk("bp_accepted", pi, 32);
    chk("bp_full_ready", rep_ready, 0);
    chk("bp_arvalid", bus.arvalid, 1);
    chk("bp_araddr", bus.araddr, 32'h1000);
    rep_valid = 0; #1;
    chk("bp_ready_no_valid", rep_ready, 0);
    rep_hdr_ar = 0; rep_hdr_aw = 1; #1;
    chk("bp_ready_other_hdr", rep_ready, 1);
    rep_hdr_aw = 0; rep_hdr_ar = 1; rep_valid = 1;
    bus.arready = 1;
    ar_run(20, 0);
    #1;
    chk("bp_issued8", k, 8);
    chk("bp_rd_out8", rd_outstanding, 8);
    chk("bp_withheld", bus.arvalid, 0);
    chk("bp_all_accepted", pi, 40);
    ar_run(60, 1);
    #1;
    chk("bp_issued_all", k, 40);
    chk("bp_returned_all", nr, 40);
    chk("bp_rd_out0", rd_outstanding, 0);
    chk("bp_idle", idle, 1);
    chk("bp_no_err", resp_err, 0);

    // R handshake at zero outstanding
    bus.rvalid = 1; bus.rresp = 2'b00;
    @(negedge clk); bus.rvalid = 0; #1;
    chk("uf_rd_out", rd_outstanding, 0);
    chk("uf_err", resp_err, 1);

    // Full W FIFO with same-cycle pop: push refused
    bus.wready = 0; pw = 0;
    rep_valid = 1; rep_hdr_w = 1; rep_wstrb = 4'hF; rep_wdata = 32'hA000;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (rep_valid && rep_ready) pw++;
      @(negedge clk);
      rep_wdata = 32'hA000 + 32'(pw);
    end
    #1;
    chk("wf_accepted", pw, 32);
    bus.wready = 1; #1;
    chk("wf_push_refused", rep_ready, 0);
    chk("wf_wvalid", bus.wvalid, 1);
    chk("wf_head0", bus.wdata, 32'hA000);
    @(negedge clk); #1;
    chk("wf_ready_again", rep_ready, 1);
    chk("wf_head1", bus.wdata, 32'hA001);
    @(negedge clk); rep_valid = 0; rep_hdr_w = 0;
    nw = 2;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.wvalid && bus.wready) begin
        chk("wf_order", bus.wdata, 32'hA000 + 32'(nw));
        nw++;
      end
      @(negedge clk);
    end
    #1;
    chk("wf_beats", nw, 33);
    chk("wf_empty", bus.wvalid, 0);
    chk("wf_idle", idle, 1);

    // Reset mid-flight: 2 writes outstanding, 5 reads buffered
    bus.awready = 1; bus.arready = 0;
    send(1, 0, 0, 32'h500, 0, 0, 0);
    send(1, 0, 0, 32'h504, 0, 0, 0);
    for (int i = 0; i < 5; i++) send(0, 0, 1, 0, 0, 0, 32'h3000 + 32'(4 * i));
    #1;
    chk("mf_wr_out2", wr_outstanding, 2);
    chk("mf_arvalid", bus.arvalid, 1);
    #1 async_rst = 1;
    #1;
    chk("mf_arvalid_rst", bus.arvalid, 0);
    chk("mf_awvalid_rst", bus.awvalid, 0);
    chk("mf_wr_out_rst", wr_outstanding, 0);
    chk("mf_idle_rst", idle, 1);
    chk("mf_ready_rst", rep_ready, 0);
    @(negedge clk);
    @(negedge clk); async_rst = 0; bus.arready = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("mf_no_residual", {bus.arvalid, bus.awvalid, bus.wvalid}, 3'b000);
      @(negedge clk);
    end
    #1;
    chk("mf_idle_after", idle, 1);
    chk("mf_rd_out_after", rd_outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
